// File: rtl/fir_mac_if.sv
// Bundle of the sample, coefficient-ROM and filtered-output signals of the
// time-multiplexed FIR engine. The producer/ROM/consumer side uses master,
// the engine itself uses slave.
interface fir_mac_if #(
    parameter int TAPS   = 32,
    parameter int COEF_W = 20
);
    localparam int AW = $clog2(TAPS);

    logic signed [15:0]       data;
    logic                     data_valid;
    logic                     data_ready;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic [15:0]              fir_d;
    logic                     fir_valid;
    logic                     busy;

    modport master (
        output data, data_valid, coef_data,
        input  data_ready, coef_addr, fir_d, fir_valid, busy
    );

    modport slave (
        input  data, data_valid, coef_data,
        output data_ready, coef_addr, fir_d, fir_valid, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one shared multiply-accumulate walks all taps
// of a circular sample buffer for every accepted sample, then emits one
// quantized output. Outputs are only strobed once the buffer holds TAPS real
// samples; the zero-cleared buffer supplies leading zeros until then.
module fir_mac_sequencer #(
    parameter int TAPS   = 32,
    parameter int COEF_W = 20
) (
    input  logic           clk,
    input  logic           rst,
    fir_mac_if.slave       bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = 16 + COEF_W;
    localparam logic [AW:0] LAST_TAP  = (AW+1)'(TAPS - 1);
    localparam logic [AW:0] WARM_FULL = (AW+1)'(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                   state_q, state_d;
    logic signed [15:0]       sampleBuf_q [TAPS];
    logic [AW-1:0]            wrPtr_q;
    logic [AW-1:0]            base_q;
    logic [AW:0]              warm_q;
    logic [AW:0]              k_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [15:0]              firD_q;
    logic                     firValid_q;

    logic                     accept;
    logic                     lastTap;
    logic [AW-1:0]            tapIdx;
    logic signed [ACC_W-1:0]  product;
    logic [15:0]              quantized;
    logic                     unusedAccBits;

    // Tap k reads the sample k positions older than the newest one.
    assign tapIdx  = base_q - k_q[AW-1:0];
    assign product = ACC_W'(sampleBuf_q[tapIdx]) * ACC_W'(bus.coef_data);

    // Guard and low-order accumulator bits are deliberately discarded by the
    // output quantizer.
    assign unusedAccBits = ^{acc_q[ACC_W-3:31], acc_q[15:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the accept/last-tap control strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        lastTap = 1'b0;
        case (state_q)
            IDLE: begin
                accept = bus.data_valid;
                if (accept) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                lastTap = (k_q == LAST_TAP);
                if (lastTap) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample capture: circular write, newest-sample pointer and warm-up count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                sampleBuf_q[i] <= '0;
            end
            wrPtr_q <= '0;
            base_q  <= '0;
            warm_q  <= '0;
        end else if (accept) begin
            sampleBuf_q[wrPtr_q] <= bus.data;
            base_q  <= wrPtr_q;
            wrPtr_q <= wrPtr_q + AW'(1);
            if (warm_q != WARM_FULL) begin
                warm_q <= warm_q + (AW+1)'(1);
            end
        end
    end

    // Multiply-accumulate: one tap per MAC cycle, cleared on every new sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            k_q   <= '0;
        end else if (accept) begin
            acc_q <= '0;
            k_q   <= '0;
        end else if (state_q == MAC) begin
            acc_q <= acc_q + product;
            k_q   <= k_q + (AW+1)'(1);
        end
    end

    // Quantizer: keep the sign, take bits 30:16, round negatives up by one.
    always_comb begin
        quantized = {acc_q[ACC_W-2], acc_q[30:16]};
        if (acc_q[ACC_W-1]) begin
            quantized = {1'b1, acc_q[30:16]} + 16'd1;
        end
    end

    // Output register: fir_d updates every OUT cycle, strobe only when warm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            firD_q     <= '0;
            firValid_q <= 1'b0;
        end else begin
            firValid_q <= 1'b0;
            if (state_q == OUT) begin
                firD_q     <= quantized;
                firValid_q <= (warm_q == WARM_FULL);
            end
        end
    end

    assign bus.data_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.coef_addr  = k_q[AW-1:0];
    assign bus.fir_d      = firD_q;
    assign bus.fir_valid  = firValid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: table-driven steady-input
// vectors, a delay-line ramp, a reset-abort sequence and randomized traffic,
// all compared against a direct convolution model.
module tb_fir_mac_sequencer;

    logic clk = 1'b0;
    logic rst;

    fir_mac_if #(.TAPS(32), .COEF_W(20)) bus ();

    fir_mac_sequencer #(.TAPS(32), .COEF_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic signed [19:0] rom [32];
    assign bus.coef_data = rom[bus.coef_addr];

    int total       = 0;
    int bad         = 0;
    int cycleCount  = 0;
    int strobeCount = 0;
    int expStrobes  = 0;
    int lastAccept  = 0;
    logic signed [15:0] hist[$];

    typedef struct {
        int          romKind;
        logic [15:0] sample;
        logic [15:0] expLast;
    } vec_t;

    vec_t vecs[6];

    // Edge counter and strobe counter, both sampled on the active edge.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (bus.fir_valid === 1'b1) strobeCount <= strobeCount + 1;
    end

    task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Direct convolution over the samples accepted since reset (older ones are zero).
    function automatic logic [15:0] modelFir();
        longint sum = 0;
        longint s36;
        longint mant;
        for (int k = 0; k < 32; k++) begin
            int idx = hist.size() - 1 - k;
            if (idx >= 0) sum += longint'(hist[idx]) * longint'(rom[k]);
        end
        s36  = sum & 64'h0000_000F_FFFF_FFFF;
        mant = (s36 >> 16) & 64'h7FFF;
        if (s36 >= 64'h8_0000_0000) return 16'(mant + 64'h8000 + 1);
        return 16'((((s36 >> 34) & 1) * 64'h8000) + mant);
    endfunction

    task automatic loadRom(input int kind);
        for (int i = 0; i < 32; i++) rom[i] = '0;
        case (kind)
            0: rom[0] = 20'sh10000;
            1: for (int i = 0; i < 32; i++) rom[i] = 20'sh08000;
            2: rom[31] = 20'sh10000;
            default: for (int i = 0; i < 32; i++) rom[i] = 20'($urandom);
        endcase
    endtask

    task automatic applyReset();
        bus.data_valid = 1'b0;
        bus.data       = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    // Offer one sample, then follow it through MAC/OUT; returns at the negedge
    // of the cycle in which the result is presented.
    task automatic applyStimulus(input logic [15:0] sample, input bit holdValid, input bit checkSpacing);
        int waited;
        int acceptEdge;
        logic [15:0] expFir;
        bit expValid;
        bit busyErr;
        bit addrErr;
        bit earlyErr;
        bus.data       = sample;
        bus.data_valid = 1'b1;
        waited = 0;
        while (bus.data_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.data_ready !== 1'b1) begin
            checkOutput("acceptTimeout", 40'(bus.data_ready), 40'd1);
            bus.data_valid = 1'b0;
            return;
        end
        @(negedge clk);
        acceptEdge = cycleCount;
        if (holdValid) bus.data = 16'($urandom);
        else bus.data_valid = 1'b0;
        if (checkSpacing) checkOutput("acceptSpacing", 40'(acceptEdge - lastAccept), 40'd34);
        lastAccept = acceptEdge;
        hist.push_back(sample);
        expFir   = modelFir();
        expValid = (hist.size() >= 32);
        if (expValid) expStrobes++;
        checkOutput("validAfterAccept", 40'(bus.fir_valid), 40'd0);
        busyErr = 0; addrErr = 0; earlyErr = 0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (bus.busy === bus.data_ready) busyErr = 1;
            if (cyc <= 32 && bus.coef_addr !== 5'(cyc - 1)) addrErr = 1;
            if (bus.data_ready !== 1'b0 || bus.fir_valid !== 1'b0) earlyErr = 1;
        end
        checkOutput("busyVsReady", 40'(busyErr), 40'd0);
        checkOutput("coefAddrSeq", 40'(addrErr), 40'd0);
        checkOutput("earlyDone", 40'(earlyErr), 40'd0);
        @(negedge clk);
        checkOutput("readyAfterOut", 40'(bus.data_ready), 40'd1);
        checkOutput("busyAfterOut", 40'(bus.busy), 40'd0);
        checkOutput("firValid", 40'(bus.fir_valid), 40'(expValid));
        checkOutput("firD", 40'(bus.fir_d), 40'(expFir));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int startStrobes;
        int gap;
        bus.data_valid = 1'b0;
        bus.data       = '0;
        rst            = 1'b1;
        loadRom(0);

        vecs[0] = '{0, 16'h1234, 16'h1234};
        vecs[1] = '{0, 16'hEDCC, 16'hEDCD};
        vecs[2] = '{1, 16'h0400, 16'h4000};
        vecs[3] = '{0, 16'h8000, 16'h8001};
        vecs[4] = '{0, 16'h7FFF, 16'h7FFF};
        vecs[5] = '{0, 16'hFFFF, 16'h0000};

        @(negedge clk);
        applyReset();
        checkOutput("resetReady", 40'(bus.data_ready), 40'd1);
        checkOutput("resetBusy", 40'(bus.busy), 40'd0);
        checkOutput("resetValid", 40'(bus.fir_valid), 40'd0);
        checkOutput("resetFirD", 40'(bus.fir_d), 40'd0);
        checkOutput("resetCoefAddr", 40'(bus.coef_addr), 40'd0);

        // Steady-input vectors with data_valid held high the whole time.
        for (int v = 0; v < 6; v++) begin
            applyReset();
            loadRom(vecs[v].romKind);
            startStrobes = strobeCount;
            for (int i = 0; i < 32; i++) applyStimulus(vecs[v].sample, 1'b1, i > 0);
            bus.data_valid = 1'b0;
            checkOutput("vecFinal", 40'(bus.fir_d), 40'(vecs[v].expLast));
            @(negedge clk);
            checkOutput("vecStrobes", 40'(strobeCount - startStrobes), 40'd1);
        end

        // Ramp through the oldest tap: exercises warm-up and pointer wrap.
        applyReset();
        loadRom(2);
        startStrobes = strobeCount;
        for (int n = 1; n <= 40; n++) begin
            applyStimulus(16'(n), 1'b0, 1'b0);
            if (n == 31) checkOutput("rampNoStrobeYet", 40'(strobeCount - startStrobes), 40'd0);
            if (n == 32) checkOutput("ramp32", 40'(bus.fir_d), 40'd1);
            if (n == 40) checkOutput("ramp40", 40'(bus.fir_d), 40'd9);
        end
        @(negedge clk);
        checkOutput("rampStrobes", 40'(strobeCount - startStrobes), 40'd9);

        // Reset ten edges into a computation aborts it and restarts warm-up.
        bus.data       = 16'h5555;
        bus.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_valid = 1'b0;
        checkOutput("abortBusyBefore", 40'(bus.busy), 40'd1);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abortReady", 40'(bus.data_ready), 40'd1);
        checkOutput("abortBusy", 40'(bus.busy), 40'd0);
        checkOutput("abortValid", 40'(bus.fir_valid), 40'd0);
        checkOutput("abortFirD", 40'(bus.fir_d), 40'd0);
        checkOutput("abortCoefAddr", 40'(bus.coef_addr), 40'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        startStrobes = strobeCount;
        repeat (45) @(negedge clk);
        checkOutput("abortNoStrobe", 40'(strobeCount - startStrobes), 40'd0);
        for (int n = 1; n <= 32; n++) applyStimulus(16'(n * 3), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abortRewarm", 40'(strobeCount - startStrobes), 40'd1);
        checkOutput("abortRewarmFirD", 40'(bus.fir_d), 40'd3);

        // Randomized coefficients, samples and gaps against the model.
        applyReset();
        loadRom(3);
        for (int i = 0; i < 60; i++) begin
            gap = (i == 0) ? 0 : $urandom_range(0, 2);
            if (gap > 0) begin
                bus.data_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), (i > 0) && (gap == 0));
        end
        bus.data_valid = 1'b0;
        @(negedge clk);
        checkOutput("strobeTotal", 40'(strobeCount), 40'(expStrobes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
